xbus_multicast_ctrl: RTL and testbench
======================================

# xbus_multicast_ctrl

Downstream stage of the global buffer on the ifmap X-bus. Accepts one tagged word per cycle (data plus X-ID tag from the buffer's tag generator), compares the tag against a per-column ID table, and multicasts the word to every matching PE column. Each column acknowledges independently. A word retires only when every targeted column has taken it, so slow columns stall the buffer without losing data.

## Interface
Parameters:
- DATA_WIDTH, 16, ifmap word width
- NUM_COL, 8, PE columns on the X-bus
- ID_WIDTH, $clog2(NUM_COL)+1, tag/ID width (matches buffer X_ID width)

Ports (one clock; reset is synchronous and active-high):
- bus_clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  write one ID-table entry
- cfg_col  in  $clog2(NUM_COL)  column index to write
- cfg_id  in  ID_WIDTH  ID assigned to that column
- in_valid  in  1  upstream word valid
- in_ready  out  1  upstream word accepted this cycle when in_valid high
- in_data  in  DATA_WIDTH  ifmap word
- in_tag  in  ID_WIDTH  X-ID tag of the word
- pe_valid  out  NUM_COL  per-column word valid
- pe_ready  in  NUM_COL  per-column accept
- pe_data  out  DATA_WIDTH  held word, shared by all columns
- drop_cnt  out  16  count of words that matched no column (saturating)
- busy  out  1  a word is held with acks still pending

## Operation
- ID table: NUM_COL entries of ID_WIDTH, reset to 0. Tag 0 is the null tag and never matches, including entries at 0. Columns left at ID 0 are disabled.
- Match: mask[i] = (in_tag != 0) && (in_tag == id_table[i]). Compute from the table value before any same-cycle cfg_we write. Several columns may share an ID; this is the multicast case.
- FSM, two states:
  - EMPTY (occ=0): in_ready=1. On in_valid with mask≠0, capture data, set pend=mask, go to HOLD. On in_valid with mask=0, consume the word and drop it, increment drop_cnt (saturate at 0xFFFF), stay in EMPTY.
  - HOLD (occ=1): pe_valid = pend. acc = pend & pe_ready. Clear pend bits in acc each cycle.
    - If pend & ~acc == 0, the word retires. in_ready=1 that cycle. A same-cycle input is captured or dropped exactly as in EMPTY, giving back-to-back operation with no bubble.
    - Otherwise in_ready=0 and the state stays HOLD.
- pe_valid[i] never deasserts before pe_ready[i]. pe_data is stable while busy.
- cfg_we is accepted in any state. It takes effect from the next cycle and does not alter pend of a held word.
- Out-of-range cfg_col (≥ NUM_COL) is ignored.

## Timing
- Reset (rst high at an edge): occ=0, pend=0, id_table=0, drop_cnt=0.
  - Outputs next cycle: pe_valid=0, busy=0, pe_data=0, in_ready=1.
  - While rst is high, in_ready is forced 0.
- Latency: word accepted at edge N appears on pe_valid/pe_data from cycle N+1.
- Throughput: 1 word/cycle when every targeted column holds pe_ready high.
- in_ready is combinational from occ, pend and pe_ready. There is no combinational path from in_valid to in_ready.
- Reset mid-HOLD discards the held word and its pending acks. It is not counted in drop_cnt.

## Structure
- Package xbus_pkg:
  - ID_WIDTH helper function
  - NULL_TAG constant (0)
  - state enum (ST_EMPTY, ST_HOLD)
  - DROP_CNT_W constant (16)
- Sub-module xbus_tag_match: combinational, in_tag plus flattened id_table in, NUM_COL mask out. Reused by the future Y-bus controller.

## Test plan
- Reset, then read state: in_ready=1, pe_valid=0, drop_cnt=0. Send word 0x1234 tag 3 before any cfg writes -> dropped, drop_cnt=1, pe_valid stays 0.
- Cfg col0..2=1, col3=2. Send 0xAAAA tag 1 with all pe_ready=1 -> pe_valid=0b0000_0111 for one cycle next cycle, pe_data=0xAAAA, busy drops the following cycle.
- Same cfg. Send tag 1 with pe_ready=0b001 for 3 cycles, then 0b110 -> pend goes 0b110 then 0. in_ready low for 3 cycles. A second queued word is accepted on the retire cycle with no bubble.
- Streaming tags 1,2,1,2 with all ready -> 4 words in 4 cycles. Alternating pe_valid 0b0111/0b1000. drop_cnt unchanged.
- cfg_we col3 := 1 in the same cycle a tag-1 word is accepted -> that word's mask excludes col3. The next tag-1 word includes col3 (0b1111).
- Assert rst during HOLD with pend=0b010 -> next cycle pe_valid=0, busy=0, id_table cleared. A tag-1 word afterwards is dropped.

Source files
------------

// File: rtl/xbus_pkg.sv
// Shared types and constants for the X-bus (and future Y-bus) multicast controllers.
package xbus_pkg;

    // Width of the tag and ID fields for a bus with num_col columns.
    function automatic int unsigned id_width(input int unsigned num_col);
        return $clog2(num_col) + 1;
    endfunction

    // Tag value that never matches, even against disabled (zero) table entries.
    localparam int unsigned NULL_TAG = 0;

    // Width of the saturating drop counter.
    localparam int unsigned DROP_CNT_W = 16;

    typedef enum logic {
        ST_EMPTY,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/xbus_tag_match.sv
// Compares one tag against every column's ID and returns the multicast mask.
module xbus_tag_match
    import xbus_pkg::*;
#(
    parameter int unsigned NUM_COL  = 8,
    parameter int unsigned ID_WIDTH = id_width(NUM_COL)
) (
    input  logic [ID_WIDTH-1:0]         in_tag_i,
    input  logic [NUM_COL*ID_WIDTH-1:0] id_table_i,
    output logic [NUM_COL-1:0]          mask_o
);

    // A column matches on equal, non-null ID.
    always_comb begin
        mask_o = '0;
        for (int unsigned i = 0; i < NUM_COL; i++) begin
            mask_o[i] = (in_tag_i != ID_WIDTH'(NULL_TAG)) &&
                        (in_tag_i == id_table_i[i*ID_WIDTH +: ID_WIDTH]);
        end
    end

endmodule

// File: rtl/xbus_multicast_ctrl.sv
// Holds one tagged ifmap word and multicasts it to all matching PE columns,
// retiring it only once every targeted column has acknowledged.
module xbus_multicast_ctrl
    import xbus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_COL    = 8,
    parameter int unsigned ID_WIDTH   = id_width(NUM_COL)
) (
    input  logic                       bus_clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_COL)-1:0] cfg_col,
    input  logic [ID_WIDTH-1:0]        cfg_id,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic [ID_WIDTH-1:0]        in_tag,
    output logic [NUM_COL-1:0]         pe_valid,
    input  logic [NUM_COL-1:0]         pe_ready,
    output logic [DATA_WIDTH-1:0]      pe_data,
    output logic [DROP_CNT_W-1:0]      drop_cnt,
    output logic                       busy
);

    state_e                             state_q, state_d;
    logic [NUM_COL-1:0]                 pend_q, pend_d;
    logic [DATA_WIDTH-1:0]              data_q, data_d;
    logic [DROP_CNT_W-1:0]              drop_q, drop_d;
    logic [NUM_COL-1:0][ID_WIDTH-1:0]   id_table_q, id_table_d;

    logic [NUM_COL-1:0] mask;
    logic [NUM_COL-1:0] remain;
    logic               hold;

    // Mask uses the registered table, so a same-cycle cfg write is not seen.
    xbus_tag_match #(
        .NUM_COL  (NUM_COL),
        .ID_WIDTH (ID_WIDTH)
    ) u_tag_match (
        .in_tag_i   (in_tag),
        .id_table_i (id_table_q),
        .mask_o     (mask)
    );

    // Handshake outputs; in_ready depends only on state, pend and pe_ready.
    always_comb begin
        hold     = (state_q == ST_HOLD);
        remain   = pend_q & ~pe_ready;
        in_ready = !rst && (!hold || (remain == '0));
        pe_valid = hold ? pend_q : '0;
        pe_data  = data_q;
        busy     = hold;
        drop_cnt = drop_q;
    end

    // Next-state: ack collection, capture/drop of incoming words, table writes.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        data_d     = data_q;
        drop_d     = drop_q;
        id_table_d = id_table_q;

        if (hold) begin
            pend_d = remain;
            if (remain == '0) begin
                state_d = ST_EMPTY;
            end
        end

        // Accepting on the retire cycle gives back-to-back words with no bubble.
        if (in_valid && in_ready) begin
            if (mask != '0) begin
                data_d  = in_data;
                pend_d  = mask;
                state_d = ST_HOLD;
            end else if (drop_q != '1) begin
                drop_d = drop_q + 1'b1;
            end
        end

        if (cfg_we && (32'(cfg_col) < NUM_COL)) begin
            id_table_d[cfg_col] = cfg_id;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge bus_clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            pend_q     <= '0;
            data_q     <= '0;
            drop_q     <= '0;
            id_table_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            data_q     <= data_d;
            drop_q     <= drop_d;
            id_table_q <= id_table_d;
        end
    end

endmodule

// File: tb/tb_xbus_multicast_ctrl.sv
// Directed self-checking bench for xbus_multicast_ctrl (8 columns, 16-bit data).
module tb_xbus_multicast_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned NC = 8;
    localparam int unsigned IW = 4;

    logic          bus_clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [2:0]    cfg_col;
    logic [IW-1:0] cfg_id;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [IW-1:0] in_tag;
    logic [NC-1:0] pe_valid;
    logic [NC-1:0] pe_ready;
    logic [DW-1:0] pe_data;
    logic [15:0]   drop_cnt;
    logic          busy;

    int tests = 0;
    int fails = 0;

    always #5 bus_clk = ~bus_clk;

    xbus_multicast_ctrl #(
        .DATA_WIDTH (DW),
        .NUM_COL    (NC),
        .ID_WIDTH   (IW)
    ) dut (
        .bus_clk  (bus_clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_col  (cfg_col),
        .cfg_id   (cfg_id),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_tag   (in_tag),
        .pe_valid (pe_valid),
        .pe_ready (pe_ready),
        .pe_data  (pe_data),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then let combinational outputs settle.
    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic cfg(input logic [2:0] col, input logic [IW-1:0] id);
        cfg_we  = 1'b1;
        cfg_col = col;
        cfg_id  = id;
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic send(input logic [IW-1:0] tag, input logic [DW-1:0] data);
        in_valid = 1'b1;
        in_tag   = tag;
        in_data  = data;
    endtask

    initial begin
        rst      = 1'b1;
        cfg_we   = 1'b0;
        cfg_col  = '0;
        cfg_id   = '0;
        in_valid = 1'b0;
        in_data  = '0;
        in_tag   = '0;
        pe_ready = '0;
        #1;
        chk("in_ready_in_rst", 32'(in_ready), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_pe_valid", 32'(pe_valid), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pe_data", 32'(pe_data), 32'h0);

        // Word before any table config matches nothing and is dropped.
        send(4'd3, 16'h1234);
        tick();
        in_valid = 1'b0;
        #1;
        chk("unmatched_drop_cnt", 32'(drop_cnt), 32'h1);
        chk("unmatched_pe_valid", 32'(pe_valid), 32'h0);
        chk("unmatched_busy", 32'(busy), 32'h0);

        cfg(3'd0, 4'd1);
        cfg(3'd1, 4'd1);
        cfg(3'd2, 4'd1);
        cfg(3'd3, 4'd2);

        // Multicast with all columns ready: one cycle of pe_valid.
        pe_ready = 8'hFF;
        send(4'd1, 16'hAAAA);
        #1;
        chk("mc_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("mc_pe_valid", 32'(pe_valid), 32'h07);
        chk("mc_pe_data", 32'(pe_data), 32'hAAAA);
        chk("mc_busy", 32'(busy), 32'h1);
        chk("mc_retire_ready", 32'(in_ready), 32'h1);
        tick();
        chk("mc_busy_after", 32'(busy), 32'h0);
        chk("mc_pe_valid_after", 32'(pe_valid), 32'h0);

        // Slow columns: col0 acks first, cols 1/2 three cycles later.
        pe_ready = 8'h01;
        send(4'd1, 16'h5555);
        tick();
        send(4'd2, 16'h6666);
        #1;
        chk("slow_c1_pe_valid", 32'(pe_valid), 32'h07);
        chk("slow_c1_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("slow_c2_pe_valid", 32'(pe_valid), 32'h06);
        chk("slow_c2_in_ready", 32'(in_ready), 32'h0);
        chk("slow_c2_pe_data", 32'(pe_data), 32'h5555);
        tick();
        chk("slow_c3_pe_valid", 32'(pe_valid), 32'h06);
        chk("slow_c3_in_ready", 32'(in_ready), 32'h0);
        pe_ready = 8'h06;
        #1;
        chk("slow_retire_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("queued_pe_valid", 32'(pe_valid), 32'h08);
        chk("queued_pe_data", 32'(pe_data), 32'h6666);
        chk("queued_busy", 32'(busy), 32'h1);
        pe_ready = 8'hFF;
        tick();
        chk("queued_done_busy", 32'(busy), 32'h0);

        // Streaming 1,2,1,2 at full rate.
        send(4'd1, 16'h0101);
        tick();
        chk("stream0_pe_valid", 32'(pe_valid), 32'h07);
        chk("stream0_pe_data", 32'(pe_data), 32'h0101);
        send(4'd2, 16'h0102);
        #1;
        chk("stream1_in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("stream1_pe_valid", 32'(pe_valid), 32'h08);
        chk("stream1_pe_data", 32'(pe_data), 32'h0102);
        send(4'd1, 16'h0103);
        tick();
        chk("stream2_pe_valid", 32'(pe_valid), 32'h07);
        chk("stream2_pe_data", 32'(pe_data), 32'h0103);
        send(4'd2, 16'h0104);
        tick();
        chk("stream3_pe_valid", 32'(pe_valid), 32'h08);
        chk("stream3_pe_data", 32'(pe_data), 32'h0104);
        in_valid = 1'b0;
        tick();
        chk("stream_busy_after", 32'(busy), 32'h0);
        chk("stream_drop_cnt", 32'(drop_cnt), 32'h1);

        // Same-cycle cfg write is not seen by the word accepted that cycle.
        send(4'd1, 16'h7777);
        cfg_we  = 1'b1;
        cfg_col = 3'd3;
        cfg_id  = 4'd1;
        tick();
        cfg_we = 1'b0;
        send(4'd1, 16'h8888);
        #1;
        chk("cfgrace_pe_valid", 32'(pe_valid), 32'h07);
        chk("cfgrace_pe_data", 32'(pe_data), 32'h7777);
        tick();
        in_valid = 1'b0;
        #1;
        chk("cfgnew_pe_valid", 32'(pe_valid), 32'h0F);
        chk("cfgnew_pe_data", 32'(pe_data), 32'h8888);
        tick();

        // Reset in HOLD with only col1 pending.
        pe_ready = 8'h0D;
        send(4'd1, 16'h9999);
        tick();
        in_valid = 1'b0;
        tick();
        chk("hold_pe_valid", 32'(pe_valid), 32'h02);
        chk("hold_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("hold_rst_in_ready", 32'(in_ready), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_pe_valid", 32'(pe_valid), 32'h0);
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_pe_data", 32'(pe_data), 32'h0);
        chk("post_rst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);
        pe_ready = 8'hFF;
        send(4'd1, 16'hBEEF);
        tick();
        in_valid = 1'b0;
        #1;
        chk("cleared_table_drop", 32'(drop_cnt), 32'h1);
        chk("cleared_table_pe_valid", 32'(pe_valid), 32'h0);

        // Null tag never matches, even against zero entries.
        send(4'd0, 16'hCAFE);
        tick();
        in_valid = 1'b0;
        #1;
        chk("null_tag_drop", 32'(drop_cnt), 32'h2);
        chk("null_tag_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
